// File: rtl/ct_mod_updn_pkg.sv
// Shared types and constants for the modulo up/down counter.
// State encoding and minimum legal runtime modulus.
package ct_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ct_state_e;

    localparam int MIN_MOD = 2;

endpackage

// File: rtl/ct_mod_updn_if.sv
// Control/status bundle of the modulo up/down counter.
// slave is the counter side, master the driving side.
interface ct_mod_updn_if #(
    parameter int W = 7
);
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] mod_val;
    logic         one_shot;
    logic         start;
    logic [W-1:0] ct_out;
    logic         z;
    logic         tc;
    logic         wrap;
    logic         busy;

    modport slave (
        input  en,
        input  up,
        input  load,
        input  load_val,
        input  mod_val,
        input  one_shot,
        input  start,
        output ct_out,
        output z,
        output tc,
        output wrap,
        output busy
    );

    modport master (
        output en,
        output up,
        output load,
        output load_val,
        output mod_val,
        output one_shot,
        output start,
        input  ct_out,
        input  z,
        input  tc,
        input  wrap,
        input  busy
    );

endinterface

// File: rtl/ct_mod_updn_next.sv
// Next-count and wrap computation for one up/down step modulo M.
// M is one bit wider than the count so M = 2**W is representable.
module ct_mod_next #(
    parameter int W = 7
) (
    input  logic [W-1:0] i_ct,
    input  logic [W:0]   i_m,
    input  logic         i_up,
    output logic [W-1:0] o_nxt,
    output logic         o_wrap
);

    localparam logic [W:0]   M_ONE  = (W+1)'(1);
    localparam logic [W-1:0] CT_ONE = W'(1);

    logic [W:0] w_ct;
    logic [W:0] w_mt;

    assign w_ct = {1'b0, i_ct};
    assign w_mt = i_m - M_ONE;

    always_comb begin
        o_nxt  = i_ct;
        o_wrap = 1'b0;
        if (i_up) begin
            if (w_ct >= w_mt) begin
                o_nxt  = '0;
                o_wrap = 1'b1;
            end else begin
                o_nxt = i_ct + CT_ONE;
            end
        end else begin
            // out-of-range counts re-enter at the top
            if ((i_ct == '0) || (w_ct >= i_m)) begin
                o_nxt  = w_mt[W-1:0];
                o_wrap = 1'b1;
            end else begin
                o_nxt = i_ct - CT_ONE;
            end
        end
    end

endmodule

// File: rtl/ct_mod_updn.sv
// Modulo-M up/down counter with load, one-shot FSM and cascade carry.
// Runtime modulus falls back to N_DEF when mod_val is below 2.
module ct_mod_updn
    import ct_pkg::*;
#(
    parameter int W     = 7,
    parameter int N_DEF = 60
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ct_mod_updn_if.slave          bus
);

    generate
        if ((N_DEF < MIN_MOD) || (N_DEF > (2**W))) begin : g_bad_ndef
            $fatal(1, "ct_mod_updn: N_DEF out of range");
        end
    endgenerate

    localparam logic [W:0] M_DEF = (W+1)'(N_DEF);
    localparam logic [W:0] M_MIN = (W+1)'(MIN_MOD);
    localparam logic [W:0] M_ONE = (W+1)'(1);

    ct_state_e    r_state;
    ct_state_e    w_state_nxt;
    logic [W-1:0] r_ct;
    logic         r_wrap;

    logic [W:0]   w_mv;
    logic [W:0]   w_m;
    logic [W:0]   w_mt;
    logic [W-1:0] w_nxt;
    logic         w_wrap;
    logic         w_run;
    logic         w_step;
    logic         w_z;
    logic [W-1:0] w_ld;

    assign w_mv = {1'b0, bus.mod_val};
    assign w_m  = (w_mv >= M_MIN) ? w_mv : M_DEF;
    assign w_mt = w_m - M_ONE;

    ct_mod_next #(
        .W (W)
    ) u_next (
        .i_ct   (r_ct),
        .i_m    (w_m),
        .i_up   (bus.up),
        .o_nxt  (w_nxt),
        .o_wrap (w_wrap)
    );

    assign w_run  = (r_state == RUN);
    assign w_step = bus.en & w_run & ~bus.load;

    assign w_ld = ({1'b0, bus.load_val} >= w_m)
                ? w_mt[W-1:0]
                : bus.load_val;

    assign w_z = bus.up ? ({1'b0, r_ct} == w_mt)
                        : (r_ct == '0);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                // one_shot only matters at the wrapping step
                if (w_step && w_wrap && bus.one_shot) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ct   <= '0;
            r_wrap <= 1'b0;
        end else if (bus.load) begin
            r_ct   <= w_ld;
            r_wrap <= 1'b0;
        end else if (w_step) begin
            r_ct   <= w_nxt;
            r_wrap <= w_wrap;
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign bus.ct_out = r_ct;
    assign bus.z      = w_z;
    assign bus.tc     = w_z & w_step;
    assign bus.wrap   = r_wrap;
    assign bus.busy   = w_run;

endmodule

// File: tb/tb_ct_mod_updn.sv
// Directed bench for ct_mod_updn: single instance plus a two-stage cascade.
module tb_ct_mod_updn;
    import ct_pkg::*;

    localparam int W = 7;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    ct_mod_updn_if #(.W(W)) if_a  ();
    ct_mod_updn_if #(.W(W)) if_lo ();
    ct_mod_updn_if #(.W(W)) if_hi ();

    ct_mod_updn #(.W(W), .N_DEF(60)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    ct_mod_updn #(.W(W), .N_DEF(60)) u_lo (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_lo.slave)
    );

    ct_mod_updn #(.W(W), .N_DEF(60)) u_hi (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_hi.slave)
    );

    assign if_hi.en = if_lo.tc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        if_a.en = 0; if_a.up = 0; if_a.load = 0; if_a.load_val = '0;
        if_a.mod_val = '0; if_a.one_shot = 0; if_a.start = 0;
        if_lo.en = 0; if_lo.up = 1; if_lo.load = 0; if_lo.load_val = '0;
        if_lo.mod_val = 7'd10; if_lo.one_shot = 0; if_lo.start = 0;
        if_hi.up = 1; if_hi.load = 0; if_hi.load_val = '0;
        if_hi.mod_val = 7'd10; if_hi.one_shot = 0; if_hi.start = 0;

        // reset state
        tick();
        chk("rst_ct", 32'(if_a.ct_out), 0);
        chk("rst_busy", 32'(if_a.busy), 0);
        chk("rst_wrap", 32'(if_a.wrap), 0);
        chk("rst_state", 32'(u_a.r_state), 32'(IDLE));
        chk("idle_z", 32'(if_a.z), 1);
        chk("idle_tc", 32'(if_a.tc), 0);

        // free-run up with default modulus 60
        rst_n = 1'b1;
        if_a.start = 1; if_a.en = 1; if_a.up = 1;
        tick();
        chk("start_busy", 32'(if_a.busy), 1);
        chk("start_ct", 32'(if_a.ct_out), 0);
        if_a.start = 0;
        for (int i = 1; i < 60; i++) begin
            tick();
            chk("up60_ct", 32'(if_a.ct_out), 32'(i));
            chk("up60_wrap", 32'(if_a.wrap), 0);
        end
        chk("z59", 32'(if_a.z), 1);
        chk("tc59", 32'(if_a.tc), 1);
        tick();
        chk("wrap60_ct", 32'(if_a.ct_out), 0);
        chk("wrap60_pulse", 32'(if_a.wrap), 1);
        chk("z0_up", 32'(if_a.z), 0);
        tick();
        chk("after_wrap_ct", 32'(if_a.ct_out), 1);
        chk("after_wrap_pulse", 32'(if_a.wrap), 0);

        // one-shot down with M = 10
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        if_a.mod_val = 7'd10; if_a.up = 0; if_a.one_shot = 1;
        if_a.en = 0; if_a.start = 1;
        tick();
        if_a.start = 0; if_a.en = 1;
        #1;
        chk("os_tc0", 32'(if_a.tc), 1);
        tick();
        chk("os_ct", 32'(if_a.ct_out), 9);
        chk("os_wrap", 32'(if_a.wrap), 1);
        chk("os_busy", 32'(if_a.busy), 0);
        chk("os_state", 32'(u_a.r_state), 32'(DONE));
        tick();
        chk("os_hold_ct", 32'(if_a.ct_out), 9);
        chk("os_hold_wrap", 32'(if_a.wrap), 0);

        // load clamping with M = 60
        if_a.mod_val = '0; if_a.load = 1; if_a.load_val = 7'd100;
        tick();
        chk("ld100_ct", 32'(if_a.ct_out), 59);
        chk("ld_state", 32'(u_a.r_state), 32'(DONE));
        if_a.load_val = 7'd60;
        tick();
        chk("ld60_ct", 32'(if_a.ct_out), 59);

        // load beats a pending wrap step
        if_a.load = 0; if_a.start = 1;
        tick();
        chk("rerun_ct", 32'(if_a.ct_out), 59);
        chk("rerun_busy", 32'(if_a.busy), 1);
        if_a.start = 0; if_a.up = 1;
        if_a.load = 1; if_a.load_val = 7'd5;
        #1;
        chk("ldwrap_tc", 32'(if_a.tc), 0);
        tick();
        chk("ldwrap_ct", 32'(if_a.ct_out), 5);
        chk("ldwrap_pulse", 32'(if_a.wrap), 0);
        chk("ldwrap_state", 32'(u_a.r_state), 32'(RUN));

        // modulus shrinks below the current count
        if_a.en = 0; if_a.load_val = 7'd50;
        tick();
        chk("ld50_ct", 32'(if_a.ct_out), 50);
        if_a.load = 0; if_a.one_shot = 0;
        if_a.mod_val = 7'd20; if_a.en = 1;
        tick();
        chk("m20_up_ct", 32'(if_a.ct_out), 0);
        chk("m20_up_wrap", 32'(if_a.wrap), 1);
        chk("m20_state", 32'(u_a.r_state), 32'(RUN));
        if_a.en = 0; if_a.load = 1; if_a.mod_val = '0;
        tick();
        chk("ld50b_ct", 32'(if_a.ct_out), 50);
        if_a.load = 0; if_a.mod_val = 7'd20;
        if_a.up = 0; if_a.en = 1;
        tick();
        chk("m20_dn_ct", 32'(if_a.ct_out), 19);
        chk("m20_dn_wrap", 32'(if_a.wrap), 1);
        tick();
        chk("m20_dn2_ct", 32'(if_a.ct_out), 18);

        // reset wins over load/start mid-RUN
        rst_n = 1'b0; if_a.load = 1; if_a.start = 1;
        if_a.load_val = 7'd7;
        tick();
        chk("rrun_ct", 32'(if_a.ct_out), 0);
        chk("rrun_state", 32'(u_a.r_state), 32'(IDLE));
        chk("rrun_wrap", 32'(if_a.wrap), 0);
        chk("rrun_busy", 32'(if_a.busy), 0);
        rst_n = 1'b1; if_a.load = 0; if_a.start = 0; if_a.en = 0;

        // cascade: 0..99 across two mod-10 stages
        if_lo.start = 1; if_hi.start = 1; if_lo.en = 1;
        tick();
        if_lo.start = 0; if_hi.start = 0;
        chk("cas_0", 32'(if_hi.ct_out) * 10 + 32'(if_lo.ct_out), 0);
        for (int k = 1; k < 100; k++) begin
            tick();
            chk("cas_seq",
                32'(if_hi.ct_out) * 10 + 32'(if_lo.ct_out), 32'(k));
        end
        chk("cas_tc99", 32'(if_lo.tc), 1);
        tick();
        chk("cas_roll_lo", 32'(if_lo.ct_out), 0);
        chk("cas_roll_hi", 32'(if_hi.ct_out), 0);
        chk("cas_roll_wrap", 32'(if_hi.wrap), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
